// File: rtl/redirect_ctrl_pkg.sv
// Shared types for the frontend redirect sequencer.
//   rdr_state_e : sequencer states (boot, idle, drain, issue)
//   rdr_cause_e : redirect cause codes; the numeric value doubles as the
//                 priority level used when comparing an override request
//                 against the held redirect.
package redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RDR_BOOT,
        RDR_IDLE,
        RDR_DRAIN,
        RDR_ISSUE
    } rdr_state_e;

    typedef enum logic [1:0] {
        RDR_CAUSE_BRANCH  = 2'b00,
        RDR_CAUSE_REFETCH = 2'b01,
        RDR_CAUSE_ERTN    = 2'b10,
        RDR_CAUSE_EXCP    = 2'b11
    } rdr_cause_e;

endpackage

// File: rtl/redirect_ctrl_prio.sv
// Combinational 4-way priority encoder for redirect requests.
// Priority: excp > ertn > refetch > branch.
// Ports:
//   excp_req, ertn_req, refetch_req, branch_req : request inputs
//   req_any : at least one request asserted
//   level   : 2-bit level of the winning request (0 when none)
module redirect_prio
    import redirect_ctrl_pkg::*;
(
    input  logic       excp_req,
    input  logic       ertn_req,
    input  logic       refetch_req,
    input  logic       branch_req,
    output logic       req_any,
    output rdr_cause_e level
);

    always_comb begin
        req_any = excp_req | ertn_req | refetch_req | branch_req;
        level   = RDR_CAUSE_BRANCH;
        if (excp_req) begin
            level = RDR_CAUSE_EXCP;
        end else if (ertn_req) begin
            level = RDR_CAUSE_ERTN;
        end else if (refetch_req) begin
            level = RDR_CAUSE_REFETCH;
        end
    end

endmodule

// File: rtl/redirect_ctrl.sv
// Redirect sequencer between the pipeline control block and the PC/icache
// front end. Latches the highest-priority redirect, holds the PC stage while
// outstanding icache fetches drain (bounded by DRAIN_TIMEOUT), then presents
// the redirect with a valid/ready handshake. Issues a boot redirect to
// RESET_PC after reset.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   *_req_i           : redirect requests (excp > ertn > refetch > branch)
//   new_pc_i          : target of this cycle's winning request
//   icache_busy_i     : icache fetch still in flight
//   fe_ready_i        : PC stage accepts the redirect
//   redirect_valid_o  : redirect presented (ISSUE state)
//   redirect_pc_o     : held redirect target
//   redirect_cause_o  : held redirect cause
//   frontend_hold_o   : PC stage paused (any state except IDLE)
//   drain_timeout_o   : sticky, a drain ended by timeout
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h1c00_0000,
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        excp_req_i,
    input  logic        ertn_req_i,
    input  logic        refetch_req_i,
    input  logic        branch_req_i,
    input  logic [31:0] new_pc_i,
    input  logic        icache_busy_i,
    input  logic        fe_ready_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic [1:0]  redirect_cause_o,
    output logic        frontend_hold_o,
    output logic        drain_timeout_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    rdr_state_e       state_q, state_d;
    rdr_cause_e       cause_q, cause_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    logic             req_any;
    rdr_cause_e       req_level;
    logic             capture;

    redirect_prio u_prio (
        .excp_req    (excp_req_i),
        .ertn_req    (ertn_req_i),
        .refetch_req (refetch_req_i),
        .branch_req  (branch_req_i),
        .req_any     (req_any),
        .level       (req_level)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        capture = 1'b0;

        case (state_q)
            RDR_BOOT: begin
                state_d = RDR_ISSUE;
                pc_d    = RESET_PC;
                cause_d = RDR_CAUSE_EXCP;
            end
            RDR_IDLE: begin
                capture = req_any;
            end
            RDR_DRAIN: begin
                // An override wins over both the normal and the timeout exit.
                if (req_any && (req_level >= cause_q)) begin
                    capture = 1'b1;
                end else if (!icache_busy_i) begin
                    state_d = RDR_ISSUE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RDR_ISSUE;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RDR_ISSUE: begin
                // With a handshake any request is a fresh capture; without
                // one only an equal-or-higher level may displace the held one.
                if (req_any && (fe_ready_i || (req_level >= cause_q))) begin
                    capture = 1'b1;
                end else if (fe_ready_i) begin
                    state_d = RDR_IDLE;
                end
            end
            default: begin
                state_d = RDR_BOOT;
            end
        endcase

        if (capture) begin
            pc_d    = new_pc_i;
            cause_d = req_level;
            cnt_d   = '0;
            state_d = icache_busy_i ? RDR_DRAIN : RDR_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RDR_BOOT;
            cause_q <= RDR_CAUSE_BRANCH;
            pc_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign redirect_valid_o = (state_q == RDR_ISSUE);
    assign frontend_hold_o  = (state_q != RDR_IDLE);
    assign redirect_pc_o    = pc_q;
    assign redirect_cause_o = cause_q;
    assign drain_timeout_o  = tmo_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
module tb_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int          TMO      = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        excp_req_i, ertn_req_i, refetch_req_i, branch_req_i;
    logic [31:0] new_pc_i;
    logic        icache_busy_i, fe_ready_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [1:0]  redirect_cause_o;
    logic        frontend_hold_o, drain_timeout_o;

    int total = 0;
    int bad   = 0;

    redirect_ctrl #(
        .RESET_PC      (RESET_PC),
        .DRAIN_TIMEOUT (TMO),
        .CNT_W         (7)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .excp_req_i       (excp_req_i),
        .ertn_req_i       (ertn_req_i),
        .refetch_req_i    (refetch_req_i),
        .branch_req_i     (branch_req_i),
        .new_pc_i         (new_pc_i),
        .icache_busy_i    (icache_busy_i),
        .fe_ready_i       (fe_ready_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_cause_o (redirect_cause_o),
        .frontend_hold_o  (frontend_hold_o),
        .drain_timeout_o  (drain_timeout_o)
    );

    always #5 clk = ~clk;

    // Reference model: a redirect is either absent, waiting for the icache
    // to go quiet (with an age count), or being offered to the PC stage.
    bit          m_booting;
    bit          m_have;
    bit          m_waiting;
    int          m_age;
    bit          m_sticky;
    logic [31:0] m_pc;
    int          m_cause;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int winner_level();
        bit [3:0] reqs;
        int lvl;
        reqs = {excp_req_i, ertn_req_i, refetch_req_i, branch_req_i};
        lvl = -1;
        for (int i = 3; i >= 0; i--)
            if (reqs[i] && lvl < 0) lvl = i;
        return lvl;
    endfunction

    task automatic model_step();
        int  lvl;
        bit  offering;
        bit  take;
        if (rst) begin
            m_booting = 1; m_have = 1; m_waiting = 0; m_age = 0;
            m_sticky = 0; m_pc = '0; m_cause = 0;
            return;
        end
        if (m_booting) begin
            m_booting = 0; m_waiting = 0; m_pc = RESET_PC; m_cause = 3;
            return;
        end
        lvl      = winner_level();
        offering = m_have && !m_waiting;
        take     = (lvl >= 0) && (!m_have || (offering && fe_ready_i) || lvl >= m_cause);
        if (take) begin
            m_pc = new_pc_i; m_cause = lvl; m_have = 1;
            m_waiting = icache_busy_i; m_age = 0;
        end else if (offering && fe_ready_i) begin
            m_have = 0;
        end else if (m_waiting) begin
            if (!icache_busy_i) begin
                m_waiting = 0; m_age = 0;
            end else if (m_age == TMO - 1) begin
                m_waiting = 0; m_age = 0; m_sticky = 1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("valid", 32'(redirect_valid_o), 32'(m_have && !m_waiting && !m_booting));
        check("hold",  32'(frontend_hold_o),  32'(m_have || m_booting));
        check("pc",    redirect_pc_o,         m_pc);
        check("cause", 32'(redirect_cause_o), 32'(m_cause));
        check("tmo",   32'(drain_timeout_o),  32'(m_sticky));
    endtask

    task automatic set_req(input bit e, input bit r, input bit f, input bit b, input logic [31:0] pc);
        excp_req_i = e; ertn_req_i = r; refetch_req_i = f; branch_req_i = b; new_pc_i = pc;
    endtask

    initial begin
        rst = 1; set_req(0, 0, 0, 0, '0); icache_busy_i = 0; fe_ready_i = 1;

        // 1: boot redirect
        tick();
        check("rst_valid", 32'(redirect_valid_o), 32'd0);
        check("rst_hold",  32'(frontend_hold_o),  32'd1);
        check("rst_pc",    redirect_pc_o,         32'd0);
        rst = 0;
        tick();
        check("boot_valid", 32'(redirect_valid_o), 32'd1);
        check("boot_pc",    redirect_pc_o,         32'h1c00_0000);
        check("boot_cause", 32'(redirect_cause_o), 32'd3);
        tick();
        check("boot_done_valid", 32'(redirect_valid_o), 32'd0);
        check("boot_done_hold",  32'(frontend_hold_o),  32'd0);

        // 2: branch held while not ready
        fe_ready_i = 0; set_req(0, 0, 0, 1, 32'h1c00_0100);
        tick();
        set_req(0, 0, 0, 0, '0);
        repeat (3) tick();
        check("br_hold_valid", 32'(redirect_valid_o), 32'd1);
        check("br_hold_pc",    redirect_pc_o,         32'h1c00_0100);
        fe_ready_i = 1;
        tick();
        check("br_accept_hold", 32'(frontend_hold_o), 32'd0);

        // 3: exception beats branch in the same cycle
        fe_ready_i = 0; set_req(1, 0, 0, 1, 32'h1c00_8000);
        tick();
        check("prio_cause", 32'(redirect_cause_o), 32'd3);
        check("prio_pc",    redirect_pc_o,         32'h1c00_8000);
        set_req(0, 0, 0, 0, '0); fe_ready_i = 1;
        tick();

        // 4: ertn in DRAIN, branch dropped, exception overrides
        fe_ready_i = 0; icache_busy_i = 1; set_req(0, 1, 0, 0, 32'h1c00_0200);
        tick();
        set_req(0, 0, 0, 0, '0);
        repeat (5) tick();
        set_req(0, 0, 0, 1, 32'h1c00_dead);
        tick();
        check("drop_pc",    redirect_pc_o,         32'h1c00_0200);
        check("drop_cause", 32'(redirect_cause_o), 32'd2);
        set_req(1, 0, 0, 0, 32'h1c00_8000);
        tick();
        check("ovr_pc",    redirect_pc_o,         32'h1c00_8000);
        check("ovr_cause", 32'(redirect_cause_o), 32'd3);
        set_req(0, 0, 0, 0, '0);
        repeat (3) tick();
        icache_busy_i = 0; fe_ready_i = 1;
        repeat (2) tick();

        // 5: drain timeout
        fe_ready_i = 0; icache_busy_i = 1; set_req(0, 0, 0, 1, 32'h1c00_0400);
        tick();
        set_req(0, 0, 0, 0, '0);
        repeat (TMO - 1) tick();
        check("tmo_pre_valid", 32'(redirect_valid_o), 32'd0);
        tick();
        check("tmo_valid", 32'(redirect_valid_o), 32'd1);
        check("tmo_flag",  32'(drain_timeout_o),  32'd1);
        repeat (100 - TMO) tick();
        icache_busy_i = 0; fe_ready_i = 1;
        tick();
        check("tmo_sticky", 32'(drain_timeout_o), 32'd1);

        // 6: reset while in ISSUE
        fe_ready_i = 0; set_req(0, 0, 1, 0, 32'h1c00_0600);
        tick();
        set_req(0, 0, 0, 0, '0);
        rst = 1;
        tick();
        check("rst6_valid", 32'(redirect_valid_o), 32'd0);
        check("rst6_tmo",   32'(drain_timeout_o),  32'd0);
        rst = 0;
        tick();
        check("reboot_pc", redirect_pc_o, RESET_PC);
        fe_ready_i = 1;
        tick();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) icache_busy_i = ~icache_busy_i;
            fe_ready_i = $urandom_range(0, 1);
            excp_req_i    = ($urandom_range(0, 19) == 0);
            ertn_req_i    = ($urandom_range(0, 14) == 0);
            refetch_req_i = ($urandom_range(0, 11) == 0);
            branch_req_i  = ($urandom_range(0, 5) == 0);
            new_pc_i      = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
